// File: rtl/updown_counter.sv
// ---------------------------------------------------------------------------
// updown_counter
//
// Purpose:
//   Enabled, direction-selectable 6-bit modulo counter for the board top
//   level. A prescaler divides the 50 MHz board clock into a count tick. On
//   each tick the count moves up or down inside the range 0..preload. The
//   count and the preload are each shown as two decimal digits on active-low
//   7-segment displays. LEDs show the count in binary and a tick toggle.
//
// Configuration macro:
//   COUNTER_FAST_TICK_EN - when defined, the prescaler is bypassed and every
//                          enabled clock is a tick (simulation speed-up).
//
// Ports:
//   clk_50MHz               in   1  board clock, rising edge
//   rst_n                   in   1  asynchronous active-low reset
//   updown_toggle           in   1  0 = count up, 1 = count down
//   ena                     in   1  count enable, 0 freezes count and prescaler
//   preload                 in   6  top of the count range 0..preload
//   count_clk_show          out  1  LED, toggles on every tick
//   count_value_number_show out  6  LEDs, current count in binary
//   DISP0_preload           out  8  7-seg, ones digit of preload
//   DISP1_preload           out  8  7-seg, tens digit of preload
//   DISP0                   out  8  7-seg, ones digit of the count
//   DISP1                   out  8  7-seg, tens digit of the count
// ---------------------------------------------------------------------------
module updown_counter #(
    parameter int CLK_DIV = 25_000_000
) (
    input  logic       clk_50MHz,
    input  logic       rst_n,
    input  logic       updown_toggle,
    input  logic       ena,
    input  logic [5:0] preload,
    output logic       count_clk_show,
    output logic [5:0] count_value_number_show,
    output logic [7:0] DISP0_preload,
    output logic [7:0] DISP1_preload,
    output logic [7:0] DISP0,
    output logic [7:0] DISP1
);

    // Tens digit of a 0..63 value, built from compares instead of a divider.
    function automatic logic [3:0] tens_of(input logic [5:0] v);
        if (v >= 6'd60)      return 4'd6;
        else if (v >= 6'd50) return 4'd5;
        else if (v >= 6'd40) return 4'd4;
        else if (v >= 6'd30) return 4'd3;
        else if (v >= 6'd20) return 4'd2;
        else if (v >= 6'd10) return 4'd1;
        else                 return 4'd0;
    endfunction

    // The ones digit is always below 10, so the low 4 bits of the remainder
    // are sufficient.
    function automatic logic [3:0] ones_of(input logic [5:0] v);
        return 4'(v - ({2'b00, tens_of(v)} * 6'd10));
    endfunction

    // Active-low segments, bit 0 = a .. bit 6 = g, bit 7 = decimal point (off).
    function automatic logic [7:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    return 8'hC0;
            4'd1:    return 8'hF9;
            4'd2:    return 8'hA4;
            4'd3:    return 8'hB0;
            4'd4:    return 8'h99;
            4'd5:    return 8'h92;
            4'd6:    return 8'h82;
            4'd7:    return 8'hF8;
            4'd8:    return 8'h80;
            4'd9:    return 8'h90;
            default: return 8'hFF;
        endcase
    endfunction

    logic       tick;
    logic [5:0] cnt_q, cnt_d;
    logic       show_q, show_d;

`ifdef COUNTER_FAST_TICK_EN
    // Every enabled clock is a tick; no prescaler state exists in this build.
    assign tick = ena;
`else
    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);

    logic [PW-1:0] presc_q, presc_d;

    // The prescaler only advances on enabled cycles, and the tick is raised
    // in the cycle where it sits at its last value.
    always_comb begin
        presc_d = presc_q;
        tick    = 1'b0;
        if (ena) begin
            if (presc_q == PRESC_LAST) begin
                presc_d = '0;
                tick    = 1'b1;
            end else begin
                presc_d = presc_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_50MHz or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end
`endif

    // Up wraps to 0 at or beyond preload; down wraps to preload at 0 or when
    // the count sits above a lowered preload. With preload = 0 both rules
    // hold the count at 0.
    always_comb begin
        cnt_d  = cnt_q;
        show_d = show_q;
        if (tick) begin
            show_d = ~show_q;
            if (!updown_toggle) begin
                cnt_d = (cnt_q >= preload) ? 6'd0 : cnt_q + 6'd1;
            end else begin
                cnt_d = ((cnt_q == 6'd0) || (cnt_q > preload)) ? preload : cnt_q - 6'd1;
            end
        end
    end

    always_ff @(posedge clk_50MHz or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= 6'd0;
            show_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            show_q <= show_d;
        end
    end

    assign count_clk_show          = show_q;
    assign count_value_number_show = cnt_q;

    assign DISP0         = seg7(ones_of(cnt_q));
    assign DISP1         = seg7(tens_of(cnt_q));
    assign DISP0_preload = seg7(ones_of(preload));
    assign DISP1_preload = seg7(tens_of(preload));

endmodule

// File: tb/tb_updown_counter.sv
// ---------------------------------------------------------------------------
// tb_updown_counter
//
// Self-checking bench for updown_counter. A behavioural model of the
// prescaler and count is advanced whenever stimulus is driven; the expected
// state is queued and compared once the DUT has clocked.
// ---------------------------------------------------------------------------
module tb_updown_counter;

    localparam int CLK_DIV = 3;
`ifdef COUNTER_FAST_TICK_EN
    localparam int TICK_P = 1;
`else
    localparam int TICK_P = CLK_DIV;
`endif

    localparam logic [7:0] SEG_TABLE [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                              8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

    typedef struct {
        int cnt;
        int show;
    } exp_t;

    exp_t expQ[$];

    logic       clk_50MHz;
    logic       rst_n;
    logic       updown_toggle;
    logic       ena;
    logic [5:0] preload;
    logic       count_clk_show;
    logic [5:0] count_value_number_show;
    logic [7:0] DISP0_preload;
    logic [7:0] DISP1_preload;
    logic [7:0] DISP0;
    logic [7:0] DISP1;

    int numChecks = 0;
    int numFails  = 0;

    int mCnt   = 0;
    int mPresc = 0;
    int mShow  = 0;

    updown_counter #(.CLK_DIV(CLK_DIV)) dut (
        .clk_50MHz               (clk_50MHz),
        .rst_n                   (rst_n),
        .updown_toggle           (updown_toggle),
        .ena                     (ena),
        .preload                 (preload),
        .count_clk_show          (count_clk_show),
        .count_value_number_show (count_value_number_show),
        .DISP0_preload           (DISP0_preload),
        .DISP1_preload           (DISP1_preload),
        .DISP0                   (DISP0),
        .DISP1                   (DISP1)
    );

    // 40 ns board clock for the bench.
    initial clk_50MHz = 1'b0;
    always #20 clk_50MHz = ~clk_50MHz;

    // Hard stop in case the sequence ever stalls.
    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [7:0] segOf(input int d);
        return SEG_TABLE[d];
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        numChecks++;
        if (observed !== expected) begin
            numFails++;
            $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic checkPreloadDisplays(input int pre);
        checkOutput("DISP1_preload", 32'(DISP1_preload), 32'(segOf(pre / 10)));
        checkOutput("DISP0_preload", 32'(DISP0_preload), 32'(segOf(pre % 10)));
    endtask

    task automatic checkCountDisplays(input int value);
        checkOutput("DISP1", 32'(DISP1), 32'(segOf(value / 10)));
        checkOutput("DISP0", 32'(DISP0), 32'(segOf(value % 10)));
    endtask

    // Drive one clock of stimulus, advance the model, then compare after the edge.
    task automatic applyStimulus(input logic en, input logic dir, input logic [5:0] pre);
        exp_t e;
        bit   tick;
        @(negedge clk_50MHz);
        ena           = en;
        updown_toggle = dir;
        preload       = pre;
        tick = en && (mPresc == TICK_P - 1);
        if (en) mPresc = tick ? 0 : mPresc + 1;
        if (tick) begin
            mShow = mShow ^ 1;
            if (!dir) mCnt = (mCnt >= int'(pre)) ? 0 : mCnt + 1;
            else      mCnt = (mCnt == 0 || mCnt > int'(pre)) ? int'(pre) : mCnt - 1;
        end
        e.cnt  = mCnt;
        e.show = mShow;
        expQ.push_back(e);
        @(posedge clk_50MHz);
        #1;
        if (expQ.size() == 0) begin
            checkOutput("scoreboard empty", 32'd0, 32'd1);
        end else begin
            e = expQ.pop_front();
            checkOutput("count", 32'(count_value_number_show), 32'(e.cnt));
            checkOutput("count_clk_show", 32'(count_clk_show), 32'(e.show));
            checkCountDisplays(e.cnt);
            checkPreloadDisplays(int'(pre));
        end
    endtask

    // Reset asserted away from any clock edge; outputs must clear at once.
    task automatic doReset(input int holdNs);
        @(negedge clk_50MHz);
        #5;
        rst_n = 1'b0;
        mCnt   = 0;
        mPresc = 0;
        mShow  = 0;
        #1;
        checkOutput("reset count", 32'(count_value_number_show), 32'd0);
        checkOutput("reset clk_show", 32'(count_clk_show), 32'd0);
        checkOutput("reset DISP1", 32'(DISP1), 32'hC0);
        checkOutput("reset DISP0", 32'(DISP0), 32'hC0);
        #(holdNs - 2);
        checkOutput("reset held count", 32'(count_value_number_show), 32'd0);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic runUntil(input int value, input logic en, input logic dir,
                            input logic [5:0] pre, input int budget);
        int n = 0;
        while (mCnt != value && n < budget) begin
            applyStimulus(en, dir, pre);
            n++;
        end
        if (mCnt != value) checkOutput("runUntil timeout", 32'(mCnt), 32'(value));
    endtask

    initial begin
        rst_n         = 1'b1;
        ena           = 1'b0;
        updown_toggle = 1'b0;
        preload       = 6'd35;
        #1;
        $display("[TB] preload displays for 35");
        checkOutput("DISP1_preload 35", 32'(DISP1_preload), 32'hB0);
        checkOutput("DISP0_preload 35", 32'(DISP0_preload), 32'h92);

        $display("[TB] reset 50 ns");
        doReset(50);

        $display("[TB] count up with wrap");
        runUntil(12, 1'b1, 1'b0, 6'd35, 20 * TICK_P);
        checkOutput("DISP1 at 12", 32'(DISP1), 32'hF9);
        checkOutput("DISP0 at 12", 32'(DISP0), 32'hA4);
        runUntil(35, 1'b1, 1'b0, 6'd35, 30 * TICK_P);
        for (int i = 0; i < TICK_P; i++) applyStimulus(1'b1, 1'b0, 6'd35);
        checkOutput("wrap to 0", 32'(count_value_number_show), 32'd0);

        $display("[TB] count down through 0");
        runUntil(2, 1'b1, 1'b0, 6'd35, 5 * TICK_P);
        for (int i = 0; i < 4 * TICK_P; i++) applyStimulus(1'b1, 1'b1, 6'd35);
        checkOutput("down to 34", 32'(count_value_number_show), 32'd34);

        $display("[TB] reset 140 ns mid-count");
        doReset(140);
        for (int i = 0; i < 3 * TICK_P; i++) applyStimulus(1'b1, 1'b0, 6'd35);

        $display("[TB] enable freeze");
        runUntil(7, 1'b1, 1'b0, 6'd35, 10 * TICK_P);
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0, 6'd35);
        checkOutput("frozen count", 32'(count_value_number_show), 32'd7);
        for (int i = 0; i < TICK_P; i++) applyStimulus(1'b1, 1'b0, 6'd35);

        $display("[TB] preload edges");
        runUntil(20, 1'b1, 1'b0, 6'd35, 20 * TICK_P);
        for (int i = 0; i < TICK_P; i++) applyStimulus(1'b1, 1'b0, 6'd5);
        checkOutput("shrunk preload wrap", 32'(count_value_number_show), 32'd0);
        for (int i = 0; i < 3 * TICK_P; i++) applyStimulus(1'b1, 1'b0, 6'd0);
        for (int i = 0; i < 3 * TICK_P; i++) applyStimulus(1'b1, 1'b1, 6'd0);
        checkOutput("preload 0 holds", 32'(count_value_number_show), 32'd0);

        $display("[TB] random stimulus");
        for (int i = 0; i < 150; i++) begin
            applyStimulus(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                          6'($urandom_range(0, 63)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
        $finish;
    end

endmodule
